// File: rtl/pox_window_buffer.sv
// Multi-channel circular sample window for the pulse-ox front end.
// Each channel keeps its last DEPTH samples in one shared RAM at {ch, ptr}.
// Every DEPTH writes a channel publishes a frame by snapshotting its write
// pointer, so a consumer can read oldest-first while new samples keep arriving.
module pox_window_buffer #(
  parameter int DATA_W = 22,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10,
  parameter int NUM_CH = 2,
  parameter int CH_W   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_valid,
  input  logic [CH_W-1:0]          wr_ch,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  input  logic [CH_W-1:0]          rd_ch,
  input  logic [ADDR_W-1:0]        rd_idx,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic [NUM_CH-1:0]        frame_ready,
  input  logic [NUM_CH-1:0]        frame_ack,
  output logic [NUM_CH-1:0]        overrun,
  output logic [NUM_CH*ADDR_W-1:0] fill_cnt
);

  // RAM address width; channel numbers >= NUM_CH never reach the RAM, so the
  // unused high bits of {ch, ptr} can be dropped.
  localparam int RA_W = $clog2(NUM_CH*DEPTH);

  typedef enum logic {FILLING = 1'b0, READY = 1'b1} st_e;

  logic [DATA_W-1:0] ram [NUM_CH*DEPTH];

  logic [ADDR_W-1:0] wr_ptr   [NUM_CH];
  logic [ADDR_W-1:0] base_ptr [NUM_CH];
  logic [ADDR_W:0]   fill     [NUM_CH];

  logic              wr_ok, rd_ok;
  logic [ADDR_W-1:0] wr_ptr_sel, rd_base, rd_off;
  logic [RA_W-1:0]   wr_pa, rd_pa;

  assign wr_ok = wr_valid && ({1'b0, wr_ch} < (CH_W+1)'(NUM_CH));
  assign rd_ok = {1'b0, rd_ch} < (CH_W+1)'(NUM_CH);

  // Select the addressed channel's write pointer and published base
  always_comb begin
    wr_ptr_sel = '0;
    rd_base    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_ch == CH_W'(c)) wr_ptr_sel = wr_ptr[c];
      if (rd_ch == CH_W'(c)) rd_base    = base_ptr[c];
    end
  end

  // Window index is relative to the oldest sample; wraps mod DEPTH
  assign rd_off = rd_base + rd_idx;
  assign wr_pa  = RA_W'({wr_ch, wr_ptr_sel});
  assign rd_pa  = RA_W'({rd_ch, rd_off});

  // Sample storage; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_ok) ram[wr_pa] <= wr_data;
  end

  // Registered read; a same-cycle write to the same word forwards the new data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        if (!rd_ok)                        rd_data <= '0;
        else if (wr_ok && (wr_pa == rd_pa)) rd_data <= wr_data;
        else                               rd_data <= ram[rd_pa];
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic              wr_hit, pub;
    logic [ADDR_W-1:0] ptr_inc;
    logic [ADDR_W:0]   fill_inc;
    st_e               st;
    logic              fr_q, ovr_q;

    assign wr_hit   = wr_ok && (wr_ch == CH_W'(c));
    assign ptr_inc  = wr_ptr[c] + ADDR_W'(1);
    assign fill_inc = fill[c] + (ADDR_W+1)'(1);
    assign pub      = wr_hit && (fill_inc == (ADDR_W+1)'(DEPTH));

    // Write pointer, fill count and frame snapshot for this channel
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr[c]   <= '0;
        base_ptr[c] <= '0;
        fill[c]     <= '0;
      end else if (wr_hit) begin
        wr_ptr[c] <= ptr_inc;
        if (pub) begin
          fill[c]     <= '0;
          base_ptr[c] <= ptr_inc;  // oldest sample of the new frame
        end else begin
          fill[c] <= fill_inc;
        end
      end
    end

    // Frame handshake FSM; a publish beats a same-cycle ack and flags overrun
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st    <= FILLING;
        fr_q  <= 1'b0;
        ovr_q <= 1'b0;
      end else begin
        case (st)
          FILLING: if (pub) begin
            st   <= READY;
            fr_q <= 1'b1;
          end
          READY: begin
            if (pub) begin
              ovr_q <= 1'b1;
            end else if (frame_ack[c]) begin
              st   <= FILLING;
              fr_q <= 1'b0;
            end
          end
          default: begin
            st   <= FILLING;
            fr_q <= 1'b0;
          end
        endcase
      end
    end

    assign frame_ready[c]                = fr_q;
    assign overrun[c]                    = ovr_q;
    assign fill_cnt[c*ADDR_W +: ADDR_W]  = fill[c][ADDR_W-1:0];
  end

endmodule

// File: tb/tb_pox_window_buffer.sv
// Directed bench for pox_window_buffer with DEPTH=8, NUM_CH=2.
// CH_W is widened to 2 so out-of-range channel numbers (2, 3) can be driven.
module tb_pox_window_buffer;
  localparam int DATA_W = 22;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
  localparam int NUM_CH = 2;
  localparam int CH_W   = 2;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     wr_valid = 1'b0;
  logic [CH_W-1:0]          wr_ch = '0;
  logic [DATA_W-1:0]        wr_data = '0;
  logic                     rd_en = 1'b0;
  logic [CH_W-1:0]          rd_ch = '0;
  logic [ADDR_W-1:0]        rd_idx = '0;
  logic [DATA_W-1:0]        rd_data;
  logic                     rd_valid;
  logic [NUM_CH-1:0]        frame_ready;
  logic [NUM_CH-1:0]        frame_ack = '0;
  logic [NUM_CH-1:0]        overrun;
  logic [NUM_CH*ADDR_W-1:0] fill_cnt;

  int checks = 0;
  int errors = 0;

  pox_window_buffer #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH), .CH_W(CH_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ch(wr_ch), .wr_data(wr_data),
    .rd_en(rd_en), .rd_ch(rd_ch), .rd_idx(rd_idx), .rd_data(rd_data), .rd_valid(rd_valid),
    .frame_ready(frame_ready), .frame_ack(frame_ack), .overrun(overrun), .fill_cnt(fill_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one clock; sample 1 ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input int d);
    wr_valid = 1'b1;
    wr_ch    = CH_W'(ch);
    wr_data  = DATA_W'(d);
    step();
    wr_valid = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input int ch, input int idx, input int exp);
    rd_en  = 1'b1;
    rd_ch  = CH_W'(ch);
    rd_idx = ADDR_W'(idx);
    step();
    rd_en  = 1'b0;
    chk({tag, "_vld"}, 32'(rd_valid), 32'd1);
    chk(tag, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    // ---- reset state
    step(); step();
    chk("rst_ready", 32'(frame_ready), 32'd0);
    chk("rst_ovr",   32'(overrun),     32'd0);
    chk("rst_fill",  32'(fill_cnt),    32'd0);
    chk("rst_rdv",   32'(rd_valid),    32'd0);
    chk("rst_rdd",   32'(rd_data),     32'd0);
    rst_n = 1'b1;
    step();

    // ---- 1: fill ch0 with 1..8, publish, read back oldest-first
    for (int k = 1; k <= 7; k++) wr(0, k);
    chk("t1_ready_pre", 32'(frame_ready), 32'd0);
    chk("t1_fill7",     32'(fill_cnt),    32'd7);
    wr(0, 8);
    chk("t1_ready", 32'(frame_ready), 32'b01);
    chk("t1_fill0", 32'(fill_cnt),    32'd0);
    for (int i = 0; i < 8; i++) rd_chk($sformatf("t1_rd%0d", i), 0, i, i + 1);
    step();
    chk("t1_idle_vld",  32'(rd_valid), 32'd0);
    chk("t1_idle_hold", 32'(rd_data),  32'd8);

    // ---- 2: keep writing without ack; addresses 0..3 now hold 9..12
    for (int k = 9; k <= 12; k++) wr(0, k);
    rd_chk("t2_idx0", 0, 0, 9);
    rd_chk("t2_idx4", 0, 4, 5);
    rd_chk("t2_idx7", 0, 7, 8);
    chk("t2_ovr_pre", 32'(overrun), 32'd0);
    for (int k = 13; k <= 16; k++) wr(0, k);
    chk("t2_ovr",   32'(overrun),     32'b01);
    chk("t2_ready", 32'(frame_ready), 32'b01);
    rd_chk("t2_new0", 0, 0, 9);
    rd_chk("t2_new7", 0, 7, 16);

    // ---- 3: interleave ch0 (17..23) and ch1 (100..107)
    for (int k = 0; k < 8; k++) begin
      if (k < 7) wr(0, 17 + k);
      wr(1, 100 + k);
      chk($sformatf("t3_rdy1_%0d", k), 32'(frame_ready[1]), 32'(k == 7));
    end
    chk("t3_fill", 32'(fill_cnt), 32'd7);  // ch0 = 7, ch1 = 0
    for (int i = 0; i < 8; i++) rd_chk($sformatf("t3_ch1_%0d", i), 1, i, 100 + i);
    rd_chk("t3_ch0_idx7", 0, 7, 16);
    chk("t3_ovr", 32'(overrun), 32'b01);

    // ---- 4: ack during the publishing write keeps the frame; ack alone drops it
    frame_ack = 2'b01;
    wr(0, 24);
    frame_ack = 2'b00;
    chk("t4_ack_pub_rdy", 32'(frame_ready), 32'b11);
    chk("t4_ack_pub_ovr", 32'(overrun),     32'b01);
    frame_ack = 2'b01; step(); frame_ack = 2'b00;
    chk("t4_ack_rdy", 32'(frame_ready), 32'b10);
    frame_ack = 2'b01; step(); frame_ack = 2'b00;
    chk("t4_ack_fill_ign", 32'(frame_ready), 32'b10);
    frame_ack = 2'b10; step(); frame_ack = 2'b00;
    chk("t4_ack1", 32'(frame_ready), 32'b00);
    chk("t4_ovr",  32'(overrun),     32'b01);

    // ---- 5: read-during-write forwarding, illegal channels
    // ch0 wr_ptr = 0 and base = 0, so idx 0 is the word being written
    rd_en = 1'b1; rd_ch = 2'd0; rd_idx = 3'd0;
    wr(0, 25);
    rd_en = 1'b0;
    chk("t5_rdw_vld", 32'(rd_valid), 32'd1);
    chk("t5_rdw",     32'(rd_data),  32'd25);
    wr(3, 99);
    chk("t5_badch_fill", 32'(fill_cnt), 32'd1);
    wr(0, 26);
    chk("t5_fill2", 32'(fill_cnt), 32'd2);
    rd_chk("t5_badrd", 2, 0, 0);
    rd_chk("t5_ptr",   0, 1, 26);
    step();
    chk("t5_hold_vld", 32'(rd_valid), 32'd0);
    chk("t5_hold",     32'(rd_data),  32'd26);

    // ---- 6: asynchronous reset mid-fill
    for (int k = 27; k <= 29; k++) wr(0, k);
    chk("t6_fill5", 32'(fill_cnt), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_ovr",  32'(overrun),  32'd0);
    chk("t6_async_fill", 32'(fill_cnt), 32'd0);
    chk("t6_async_rdd",  32'(rd_data),  32'd0);
    chk("t6_async_rdy",  32'(frame_ready), 32'd0);
    #2 rst_n = 1'b1;
    step();
    for (int k = 1; k <= 7; k++) wr(0, k);
    chk("t6_ready_pre", 32'(frame_ready), 32'd0);
    wr(0, 8);
    chk("t6_ready", 32'(frame_ready), 32'b01);
    rd_chk("t6_idx0", 0, 0, 1);
    rd_chk("t6_idx5", 0, 5, 6);
    chk("t6_ovr_clr", 32'(overrun), 32'd0);

    // READY + publish + same-cycle ack: stays ready, overrun sets
    for (int k = 9; k <= 15; k++) wr(0, k);
    frame_ack = 2'b01;
    wr(0, 16);
    frame_ack = 2'b00;
    chk("t6_ackpub_rdy", 32'(frame_ready), 32'b01);
    chk("t6_ackpub_ovr", 32'(overrun),     32'b01);
    rd_chk("t6_new0", 0, 0, 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // hard stop in case a step never returns
  initial begin
    #100000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
